seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, WIDTH, unsigned numerator; sampled with start.
REQ-006 The block SHALL have port divisor, input, WIDTH, unsigned denominator; sampled with start.
REQ-007 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-008 The block SHALL have port done, output, 1, single-cycle pulse marking a new DivAns value.
REQ-009 The block SHALL have port div_by_zero, output, 1, flag for the result on DivAns; held with DivAns.
REQ-010 The block SHALL have port DivAns, output, 2*WIDTH, result word for the HiLo register: [2*WIDTH-1:WIDTH] quotient, [WIDTH-1:0] remainder.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1 and divisor!=0, the block SHALL latch both operands, clear the iteration counter and enter RUN on that edge.
REQ-013 In RUN, each edge SHALL perform one restoring shift-subtract step: shift the remainder left, bring in the next dividend MSB, subtract the divisor when the result is >= 0, and shift the quotient bit in.
REQ-014 Subtraction SHALL use a WIDTH+1-bit compare so that divisors with MSB=1 give correct results.
REQ-015 After exactly WIDTH RUN steps, the block SHALL load DivAns with {quotient, remainder}, clear div_by_zero and enter DONE.
REQ-016 If start is sampled at edge k, done SHALL be high for exactly the cycle after edge k+WIDTH.
REQ-017 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-018 In IDLE with start=1 and divisor==0, the block SHALL enter DONE on that edge with DivAns={all ones, dividend} and div_by_zero=1, so done is high in the cycle after edge k.
REQ-019 The block SHALL ignore start while busy=1; there SHALL be no queueing.
REQ-020 Operand input changes after the start edge SHALL NOT affect the result in progress.
REQ-021 DivAns and div_by_zero SHALL hold their last values until the next completion or reset.

Reset
REQ-022 On reset=1 at a clock edge, the block SHALL enter IDLE and SHALL force busy=0, done=0, div_by_zero=0, DivAns=0 and the counter to 0.
REQ-023 A reset during RUN or DONE SHALL abort the operation with no done pulse, and reset SHALL take priority over start on the same edge.
REQ-024 The block SHALL accept a start on the first edge after reset deasserts.

Structure
REQ-025 The shared package SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-026 One step SHALL be factored into a combinational sub-module div_step (inputs: remainder, divisor, next bit; outputs: new remainder, quotient bit).
REQ-027 The counter SHALL be clog2(WIDTH)+1 bits, and no other sub-modules SHALL be used.

Verification
REQ-028 Directed test: dividend=100, divisor=7, start pulse -> done 32 cycles later, DivAns=64'h0000000E_00000002, div_by_zero=0.
REQ-029 Directed test: dividend=5, divisor=0 -> done on the next cycle, DivAns=64'hFFFFFFFF_00000005, div_by_zero=1, busy high for 1 cycle.
REQ-030 Directed test: dividend=32'hFFFFFFFF, divisor=1 -> DivAns=64'hFFFFFFFF_00000000. Also dividend=32'hFFFFFFFF, divisor=32'h80000000 -> DivAns=64'h00000001_7FFFFFFF.
REQ-031 Directed test: dividend=3, divisor=10 -> DivAns=64'h00000000_00000003. Then a second start while busy with other operands -> ignored and result unchanged.
REQ-032 Directed test: start 100/7, change the operands on the next cycle, assert reset at cycle 10 -> no done pulse, all outputs 0, busy=0, and a new start 9/3 afterwards -> DivAns=64'h00000003_00000000.

Source files
------------

// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_pkg
// Description : Shared types and constants for the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring shift-subtract division step.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    // The extra top bit keeps the shifted remainder exact and acts as the borrow.
    assign w_trial = {i_rem, i_bit};
    assign w_diff  = w_trial - {1'b0, i_divisor};
    assign o_qbit  = ~w_diff[WIDTH];
    assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] DivAns
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dsr;
    logic [WIDTH-1:0]   w_rem;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_quo;
    logic               w_last;

    // r_quo starts as the dividend and fills with quotient bits from the LSB.
    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_divisor (r_dsr),
        .i_bit     (r_quo[WIDTH-1]),
        .o_rem     (w_rem),
        .o_qbit    (w_qbit)
    );

    assign w_quo  = {r_quo[WIDTH-2:0], w_qbit};
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dsr       <= '0;
            DivAns      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            r_quo <= dividend;
                            r_dsr <= divisor;
                            r_rem <= '0;
                            r_cnt <= '0;
                        end else begin
                            DivAns      <= {{WIDTH{1'b1}}, dividend};
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem;
                    r_quo <= w_quo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        DivAns      <= {w_quo, w_rem};
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Scoreboard bench for seq_divider against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic [2*W-1:0] DivAns;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .DivAns      (DivAns)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] ans;
        logic           dbz;
        int             due;
    } exp_t;

    exp_t           sbq[$];
    int             errors = 0;
    int             checks = 0;
    int             cyc = 0;
    logic [2*W-1:0] hold_ans = '0;
    logic           hold_dbz = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        exp_t e;
        if (b == 0) begin
            e.ans = {{W{1'b1}}, a};
            e.dbz = 1'b1;
            e.due = k;
        end else begin
            e.ans = {a / b, a % b};
            e.dbz = 1'b0;
            e.due = k + W;
        end
        return e;
    endfunction

    // Monitor: scoreboard pops on done; also checks busy and result hold.
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", 64'(busy), 64'(sbq.size() != 0));
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.due));
                    chk("DivAns", DivAns, e.ans);
                    chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                    hold_ans = e.ans;
                    hold_dbz = e.dbz;
                end
            end else begin
                chk("hold_DivAns", DivAns, hold_ans);
                chk("hold_dbz", 64'(div_by_zero), 64'(hold_dbz));
                if (sbq.size() != 0 && cyc > sbq[0].due) begin
                    chk("done_timeout", 64'(cyc), 64'(sbq[0].due));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    // Entered and left at a falling edge.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_wait", 64'(busy), 64'd0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sbq.push_back(model(a, b, cyc));
        dividend = $urandom;
        divisor  = $urandom;
        @(negedge clk);
    endtask

    task automatic ignored_start(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset(input logic with_start);
        reset    = 1'b1;
        start    = with_start;
        dividend = 32'd77;
        divisor  = 32'd5;
        @(posedge clk);
        #1;
        sbq.delete();
        hold_ans = '0;
        hold_dbz = 1'b0;
        chk("rst_DivAns", DivAns, 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int n;
        logic [W-1:0] a, b;
        @(negedge clk);
        do_reset(1'b0);

        do_div(32'd100, 32'd7);
        do_div(32'd5, 32'd0);
        do_div(32'hFFFFFFFF, 32'd1);
        do_div(32'hFFFFFFFF, 32'h80000000);
        do_div(32'd3, 32'd10);
        ignored_start(32'd50, 32'd5);

        // Abort mid-run, then start on the first edge out of reset.
        do_div(32'd100, 32'd7);
        repeat (8) @(negedge clk);
        do_reset(1'b0);
        do_div(32'd9, 32'd3);
        repeat (5) @(negedge clk);
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        chk("reset_beats_start", 64'(busy), 64'd0);

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 16);
                2:       b = {1'b1, 31'($urandom)};
                3:       b = a;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_div(a, b);
            if ($urandom_range(0, 3) == 0) ignored_start($urandom, $urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sbq.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_divider
`default_nettype wire
